// File: rtl/exception_cp0.sv
// CP0 exception unit: accepts overflow / reserved-instruction requests, holds Status/Cause/EPC,
// and drives a one-cycle flush plus PC redirect to the handler vector or back to EPC on ERET.
module exception_cp0 #(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_0080,
    parameter logic [4:0]        CODE_OV    = 5'd12,
    parameter logic [4:0]        CODE_RI    = 5'd10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ov,
    input  logic [DATA_W-1:0] ov_pc,
    input  logic              ri,
    input  logic [DATA_W-1:0] ri_pc,
    input  logic              eret,
    input  logic              cp0_we,
    input  logic [4:0]        cp0_addr,
    input  logic [DATA_W-1:0] cp0_wdata,
    output logic [DATA_W-1:0] cp0_rdata,
    output logic              flush,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] epc,
    output logic              exl,
    output logic [4:0]        exc_code
);

    typedef enum logic {RUN, REDIR} state_t;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    state_t            state_q;
    logic              flush_q;
    logic              redir_q;
    logic [DATA_W-1:0] redirect_pc_q;
    logic [DATA_W-1:0] epc_q;
    logic              exl_q;
    logic [4:0]        code_q;

    logic exc_acc_d;
    logic eret_acc_d;

    // An accepted exception always has EXL=0, so it can never coincide with an accepted ERET.
    assign exc_acc_d  = (state_q == RUN) && !exl_q && (ov || ri);
    assign eret_acc_d = (state_q == RUN) && exl_q && eret && !exc_acc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            flush_q       <= 1'b0;
            redir_q       <= 1'b0;
            redirect_pc_q <= '0;
            epc_q         <= '0;
            exl_q         <= 1'b0;
            code_q        <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    flush_q <= 1'b0;
                    redir_q <= 1'b0;
                    // MTC0 first so an accepted exception/ERET overrides it below.
                    if (cp0_we) begin
                        case (cp0_addr)
                            ADDR_STATUS: exl_q  <= cp0_wdata[1];
                            ADDR_CAUSE:  code_q <= cp0_wdata[6:2];
                            ADDR_EPC:    epc_q  <= cp0_wdata;
                            default: ;
                        endcase
                    end
                    if (exc_acc_d) begin
                        epc_q         <= ov ? ov_pc : ri_pc;
                        code_q        <= ov ? CODE_OV : CODE_RI;
                        exl_q         <= 1'b1;
                        redirect_pc_q <= EXC_VECTOR;
                        flush_q       <= 1'b1;
                        redir_q       <= 1'b1;
                        state_q       <= REDIR;
                    end else if (eret_acc_d) begin
                        exl_q         <= 1'b0;
                        redirect_pc_q <= epc_q;
                        flush_q       <= 1'b1;
                        redir_q       <= 1'b1;
                        state_q       <= REDIR;
                    end
                end
                REDIR: begin
                    flush_q <= 1'b0;
                    redir_q <= 1'b0;
                    state_q <= RUN;
                end
                default: begin
                    flush_q <= 1'b0;
                    redir_q <= 1'b0;
                    state_q <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_STATUS: cp0_rdata[1]   = exl_q;
            ADDR_CAUSE:  cp0_rdata[6:2] = code_q;
            ADDR_EPC:    cp0_rdata      = epc_q;
            default:     cp0_rdata      = '0;
        endcase
    end

    assign flush       = flush_q;
    assign pc_redirect = redir_q;
    assign redirect_pc = redirect_pc_q;
    assign epc         = epc_q;
    assign exl         = exl_q;
    assign exc_code    = code_q;

endmodule

// File: tb/tb_exception_cp0.sv
// Directed bench for exception_cp0: reset, overflow, priority, ERET return, MTC0 precedence, reset mid-redirect.
module tb_exception_cp0;

    logic        clk;
    logic        reset_n;
    logic        ov;
    logic [31:0] ov_pc;
    logic        ri;
    logic [31:0] ri_pc;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic        exl;
    logic [4:0]  exc_code;

    int checks;
    int errors;

    exception_cp0 dut (
        .clk(clk), .reset_n(reset_n),
        .ov(ov), .ov_pc(ov_pc), .ri(ri), .ri_pc(ri_pc), .eret(eret),
        .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .epc(epc), .exl(exl), .exc_code(exc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ov = 1'b0; ov_pc = '0; ri = 1'b0; ri_pc = '0; eret = 1'b0;
        cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0;
    endtask

    task automatic test_reset();
        ov = 1'b1; ov_pc = 32'h0000_0010;
        step();
        ov = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        cp0_addr = 5'd12;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0h exp 0", flush); end
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL rst_redir got %0h exp 0", pc_redirect); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %08h exp 0", redirect_pc); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got %08h exp 0", epc); end
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL rst_exl got %0h exp 0", exl); end
        checks++; if (exc_code !== 5'd0) begin errors++; $display("FAIL rst_code got %0d exp 0", exc_code); end
        checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata12 got %08h exp 0", cp0_rdata); end
        @(posedge clk); #1 reset_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_overflow();
        ov = 1'b1; ov_pc = 32'h0000_0040;
        step();
        ov = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ov_flush got %0h exp 1", flush); end
        checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL ov_redir got %0h exp 1", pc_redirect); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL ov_redirect_pc got %08h exp 00000080", redirect_pc); end
        checks++; if (epc !== 32'h40) begin errors++; $display("FAIL ov_epc got %08h exp 00000040", epc); end
        checks++; if (exc_code !== 5'd12) begin errors++; $display("FAIL ov_code got %0d exp 12", exc_code); end
        checks++; if (exl !== 1'b1) begin errors++; $display("FAIL ov_exl got %0h exp 1", exl); end
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ov_flush_drop got %0h exp 0", flush); end
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL ov_redir_drop got %0h exp 0", pc_redirect); end
        // Clear EXL through MTC0 Status so the next exception is accepted.
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
        step();
        clear_inputs();
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL mtc0_status_exl got %0h exp 0", exl); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mtc0_status_flush got %0h exp 0", flush); end
    endtask

    task automatic test_simultaneous();
        ov = 1'b1; ov_pc = 32'h44; ri = 1'b1; ri_pc = 32'h48; eret = 1'b1;
        step();
        clear_inputs();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL sim_flush got %0h exp 1", flush); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL sim_redirect_pc got %08h exp 00000080", redirect_pc); end
        checks++; if (epc !== 32'h44) begin errors++; $display("FAIL sim_epc got %08h exp 00000044", epc); end
        checks++; if (exc_code !== 5'd12) begin errors++; $display("FAIL sim_code got %0d exp 12", exc_code); end
        checks++; if (exl !== 1'b1) begin errors++; $display("FAIL sim_exl got %0h exp 1", exl); end
        step();
        ri = 1'b1; ri_pc = 32'h99;
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nested_flush got %0h exp 0", flush); end
        step();
        clear_inputs();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nested_flush2 got %0h exp 0", flush); end
        checks++; if (epc !== 32'h44) begin errors++; $display("FAIL nested_epc got %08h exp 00000044", epc); end
        checks++; if (exc_code !== 5'd12) begin errors++; $display("FAIL nested_code got %0d exp 12", exc_code); end
    endtask

    task automatic test_return();
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h100;
        step();
        clear_inputs();
        checks++; if (epc !== 32'h100) begin errors++; $display("FAIL mtc0_epc got %08h exp 00000100", epc); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mtc0_epc_flush got %0h exp 0", flush); end
        eret = 1'b1;
        step();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got %0h exp 1", flush); end
        checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL eret_redir got %0h exp 1", pc_redirect); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL eret_redirect_pc got %08h exp 00000100", redirect_pc); end
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL eret_exl got %0h exp 0", exl); end
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL eret_flush_drop got %0h exp 0", flush); end
        step();
        clear_inputs();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL eret2_flush got %0h exp 0", flush); end
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL eret2_redir got %0h exp 0", pc_redirect); end
    endtask

    task automatic test_precedence();
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF; ri = 1'b1; ri_pc = 32'h20;
        step();
        clear_inputs();
        checks++; if (epc !== 32'h20) begin errors++; $display("FAIL prec_epc got %08h exp 00000020", epc); end
        checks++; if (exc_code !== 5'd10) begin errors++; $display("FAIL prec_code got %0d exp 10", exc_code); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL prec_flush got %0h exp 1", flush); end
        // MTC0 during the redirect cycle must be dropped.
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h55;
        step();
        clear_inputs();
        checks++; if (epc !== 32'h20) begin errors++; $display("FAIL redir_mtc0_epc got %08h exp 00000020", epc); end
        cp0_addr = 5'd13; #1;
        checks++; if (cp0_rdata !== 32'h28) begin errors++; $display("FAIL rd_cause got %08h exp 00000028", cp0_rdata); end
        cp0_addr = 5'd7; #1;
        checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL rd_addr7 got %08h exp 0", cp0_rdata); end
        cp0_addr = 5'd12; #1;
        checks++; if (cp0_rdata !== 32'h2) begin errors++; $display("FAIL rd_status got %08h exp 00000002", cp0_rdata); end
        cp0_addr = 5'd14; #1;
        checks++; if (cp0_rdata !== 32'h20) begin errors++; $display("FAIL rd_epc got %08h exp 00000020", cp0_rdata); end
        clear_inputs();
    endtask

    task automatic test_reset_redir();
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
        step();
        clear_inputs();
        ov = 1'b1; ov_pc = 32'h60;
        step();
        clear_inputs();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rr_flush_pre got %0h exp 1", flush); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rr_flush got %0h exp 0", flush); end
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL rr_redir got %0h exp 0", pc_redirect); end
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL rr_exl got %0h exp 0", exl); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rr_epc got %08h exp 0", epc); end
        @(posedge clk); #1 reset_n = 1'b1;
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rr_idle_flush got %0h exp 0", flush); end
        ov = 1'b1; ov_pc = 32'h70;
        step();
        clear_inputs();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rr_run_flush got %0h exp 1", flush); end
        checks++; if (epc !== 32'h70) begin errors++; $display("FAIL rr_run_epc got %08h exp 00000070", epc); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_overflow();
        test_simultaneous();
        test_return();
        test_precedence();
        test_reset_redir();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_cp0.md
Name: exception_cp0

Overview:
- Consumer side of the pipeline's exception signalling. Accepts raised exception requests: arithmetic overflow from EX, reserved/illegal instruction from ID.
- Holds the CP0 state registers Status, Cause and EPC.
- Sequences the pipeline flush and PC redirect to the handler vector, and back to EPC on ERET.
- Sits beside the PC-select mux and the hazard unit; owns the only flush source for exceptions.

Parameters:
- DATA_W, 32, width of PCs and CP0 registers
- EXC_VECTOR, 32'h0000_0080, handler entry address
- CODE_OV, 5'd12, Cause.ExcCode for overflow
- CODE_RI, 5'd10, Cause.ExcCode for reserved instruction

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ov  in  1  overflow request from EX stage
- ov_pc  in  DATA_W  PC of the overflowing instruction
- ri  in  1  reserved-instruction request from ID stage
- ri_pc  in  DATA_W  PC of the offending instruction
- eret  in  1  ERET decoded in ID
- cp0_we  in  1  MTC0 write strobe
- cp0_addr  in  5  CP0 register number (12 Status, 13 Cause, 14 EPC)
- cp0_wdata  in  DATA_W  MTC0 data
- cp0_rdata  out  DATA_W  MFC0 read data, combinational from cp0_addr
- flush  out  1  kill IF/ID/EX contents, registered
- pc_redirect  out  1  PC mux selects redirect_pc, registered
- redirect_pc  out  DATA_W  target PC, registered
- epc  out  DATA_W  EPC register
- exl  out  1  Status.EXL
- exc_code  out  5  Cause[6:2]

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low. Reset is asserted asynchronously and released synchronously by the surrounding reset logic.
- Reset values: state=RUN, EPC=0, Cause=0, Status=0 (EXL=0), flush=0, pc_redirect=0, redirect_pc=0. Reset mid-flush clears everything immediately; no redirect completes.
- FSM has two states:
  - RUN: normal operation.
  - REDIR: exactly one cycle; flush=1, pc_redirect=1, redirect_pc valid.
- flush/pc_redirect/redirect_pc are registered outputs, asserted in the cycle after the triggering edge. Latency: request sampled at edge N, redirect visible during cycle N+1, next fetch from target at edge N+2.
- Exception accept condition: state=RUN, EXL=0, and (ov or ri). On accept:
  - EPC<=ov_pc with exc_code<=CODE_OV if ov=1. Otherwise EPC<=ri_pc with exc_code<=CODE_RI.
  - Overflow wins because the EX instruction is older.
  - EXL<=1; redirect_pc<=EXC_VECTOR; state<=REDIR.
- Requests with EXL=1: ignored. EPC/Cause unchanged, no flush; nested exceptions are not supported.
- Requests during REDIR: ignored; they belong to squashed instructions.
- ERET accept condition: state=RUN, EXL=1, and no exception accepted this cycle. On accept: EXL<=0; redirect_pc<=EPC; state<=REDIR.
- ERET with EXL=0: no effect.
- ERET in REDIR: ignored.
- ERET simultaneous with an exception when EXL=0: the exception is taken and ERET is dropped.
- MTC0 (cp0_we=1):
  - Writes Status[1] (EXL only; other bits read 0).
  - Writes Cause[6:2] (other bits read 0).
  - Writes full EPC.
  - Other addresses are discarded.
  - If an exception or ERET is accepted in the same cycle, its updates to EPC/Cause/EXL take precedence over the MTC0 data.
  - MTC0 is ignored in REDIR.
- cp0_rdata: 12→{30'b0,EXL,1'b0}, 13→{25'b0,exc_code,2'b0}, 14→EPC, all other addresses read 0. Reflects register state, not a same-cycle write.
- REDIR→RUN unconditionally after one cycle; flush and pc_redirect deassert.

Test Plan:
- Reset: assert reset_n=0 mid-cycle → all outputs 0 immediately; cp0_rdata(12)=0.
- Overflow: ov=1, ov_pc=0x0000_0040, edge → next cycle flush=1, pc_redirect=1, redirect_pc=0x80; then epc=0x40, exc_code=12, exl=1; one cycle later flush=0.
- Simultaneous: ov=1/ov_pc=0x44 with ri=1/ri_pc=0x48 and eret=1 → epc=0x44, exc_code=12, redirect to 0x80. Then ri=1 while exl=1 → no flush, epc stays 0x44.
- Return: cp0_we=1, addr=14, wdata=0x0000_0100 (EPC=0x100), then eret=1 → flush for one cycle with redirect_pc=0x100, exl=0. A second eret → no flush.
- Precedence: cp0_we=1 (addr=14, wdata=0xDEAD_BEEF) together with ri=1/ri_pc=0x20 → epc=0x20, exc_code=10. Read addr=13 → 0x28; addr=7 → 0.
- Reset during REDIR: drop reset_n in the flush cycle → flush=0, exl=0, epc=0, and FSM in RUN after release.
